// File: rtl/debounce_edge.sv
// Debounce and edge-qualification stage for an already-synchronized level.
// A change is accepted after STABLE_CYCLES consecutive samples differing from dout.
module debounce_edge #(
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter logic        RESET_LEVEL   = 1'b0,
  parameter int unsigned EVT_W         = 8,
  localparam int unsigned CNT_W        = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic             toggle,
  output logic [EVT_W-1:0] evt_cnt,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Encoding chosen so bit 1 is the debounced level and bit 0 marks qualification.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    ARM_HI    = 2'b01,
    STABLE_HI = 2'b10,
    ARM_LO    = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             toggle_q, toggle_d;
  logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic             level;
  logic             differ;
  logic             commit;

  assign level  = state_q[1];
  assign differ = (din != level);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    toggle_d  = toggle_q;
    evt_cnt_d = evt_cnt_q;
    commit    = 1'b0;

    case (state_q)
      STABLE_LO, STABLE_HI: begin
        if (!differ) begin
          cnt_d = '0;
        end else if (STABLE_CYCLES == 1) begin
          commit = 1'b1;
        end else begin
          state_d = level ? ARM_LO : ARM_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      ARM_HI, ARM_LO: begin
        if (!differ) begin
          // Bounce back to the old level: abandon the candidate silently.
          state_d = level ? STABLE_HI : STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase

    if (commit) begin
      state_d = level ? STABLE_LO : STABLE_HI;
      cnt_d   = '0;
      if (!level) begin
        rise_d    = 1'b1;
        toggle_d  = ~toggle_q;
        evt_cnt_d = evt_cnt_q + EVT_W'(1);
      end else begin
        fall_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      cnt_q     <= '0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      toggle_q  <= 1'b0;
      evt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      toggle_q  <= toggle_d;
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign dout      = state_q[1];
  assign busy      = state_q[0];
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign toggle    = toggle_q;
  assign evt_cnt   = evt_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: two instances (4-cycle and 1-cycle qualification) driven
// together and checked every cycle against a run-length reference model.
module tb_debounce_edge;

  localparam int S_A = 4;
  localparam int S_B = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  always #5 clk = ~clk;

  logic       dout_a, rise_a, fall_a, toggle_a, busy_a;
  logic [7:0] evt_a;
  logic [1:0] st_a;
  logic       dout_b, rise_b, fall_b, toggle_b, busy_b;
  logic [7:0] evt_b;
  logic [1:0] st_b;

  debounce_edge #(.STABLE_CYCLES(S_A), .RESET_LEVEL(1'b0), .EVT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout_a), .rise(rise_a),
    .fall(fall_a), .toggle(toggle_a), .evt_cnt(evt_a), .busy(busy_a),
    .state_dbg(st_a)
  );

  debounce_edge #(.STABLE_CYCLES(S_B), .RESET_LEVEL(1'b0), .EVT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout_b), .rise(rise_b),
    .fall(fall_b), .toggle(toggle_b), .evt_cnt(evt_b), .busy(busy_b),
    .state_dbg(st_b)
  );

  // ---------------- reference model ----------------
  // Per instance: accepted level, length of the current run of differing samples.
  bit         m_lvl [2];
  int         m_run [2];
  bit         m_rise[2];
  bit         m_fall[2];
  bit         m_tog [2];
  logic [7:0] m_evt [2];
  logic [7:0] exp_q[$];

  int tests = 0;
  int failed = 0;
  int n_rise = 0;
  int n_fall = 0;

  task automatic model_step(input int i, input int s, input bit d, input bit r);
    m_rise[i] = 1'b0;
    m_fall[i] = 1'b0;
    if (!r) begin
      m_lvl[i] = 1'b0;
      m_run[i] = 0;
      m_tog[i] = 1'b0;
      m_evt[i] = 8'd0;
    end else if (d != m_lvl[i]) begin
      m_run[i] = m_run[i] + 1;
      if (m_run[i] == s) begin
        m_run[i] = 0;
        m_lvl[i] = d;
        if (d) begin
          m_rise[i] = 1'b1;
          m_tog[i]  = ~m_tog[i];
          m_evt[i]  = m_evt[i] + 8'd1;
          if (i == 0) exp_q.push_back(m_evt[i]);
        end else begin
          m_fall[i] = 1'b1;
        end
      end
    end else begin
      m_run[i] = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver + per-cycle scoreboard ----------------
  task automatic cycle(input bit d, input bit r);
    logic [7:0] e;
    din   = d;
    rst_n = r;
    @(posedge clk);
    model_step(0, S_A, d, r);
    model_step(1, S_B, d, r);
    #1;
    check("a_dout",   dout_a,   m_lvl[0]);
    check("a_rise",   rise_a,   m_rise[0]);
    check("a_fall",   fall_a,   m_fall[0]);
    check("a_toggle", toggle_a, m_tog[0]);
    check("a_evt",    evt_a,    m_evt[0]);
    check("a_busy",   busy_a,   m_run[0] > 0);
    check("b_dout",   dout_b,   m_lvl[1]);
    check("b_rise",   rise_b,   m_rise[1]);
    check("b_fall",   fall_b,   m_fall[1]);
    check("b_toggle", toggle_b, m_tog[1]);
    check("b_evt",    evt_b,    m_evt[1]);
    check("b_busy",   busy_b,   1'b0);
    check("a_rise_fall_excl", rise_a & fall_a, 1'b0);
    if (rise_a) begin
      n_rise++;
      if (exp_q.size() == 0) begin
        check("a_sb_unexpected_rise", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("a_sb_evt_at_rise", evt_a, e);
      end
    end
    if (fall_a) n_fall++;
  endtask

  task automatic hold(input bit d, input int n);
    for (int k = 0; k < n; k++) cycle(d, 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    logic       tog_save;
    logic [7:0] evt_save;
    int         b;

    // Reset with input high
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0);
      check("rst_dout", dout_a, 1'b0);
      check("rst_busy", busy_a, 1'b0);
      check("rst_evt",  evt_a,  8'd0);
    end
    cycle(1'b1, 1'b1);
    check("rel_busy_e1", busy_a, 1'b1);
    hold(1'b1, 2);
    check("rel_dout_e3", dout_a, 1'b0);
    hold(1'b1, 1);
    check("rel_dout_e4",   dout_a,   1'b1);
    check("rel_rise_e4",   rise_a,   1'b1);
    check("rel_toggle_e4", toggle_a, 1'b1);
    check("rel_evt_e4",    evt_a,    8'd1);
    check("rel_busy_e4",   busy_a,   1'b0);
    hold(1'b1, 1);
    check("rel_rise_one_cycle", rise_a, 1'b0);

    // Bounce rejection from STABLE_LO
    cycle(1'b0, 1'b0);
    hold(1'b0, 2);
    hold(1'b1, 3);
    check("bnc_busy_mid", busy_a, 1'b1);
    hold(1'b0, 1);
    check("bnc_dout_after0", dout_a, 1'b0);
    check("bnc_busy_after0", busy_a, 1'b0);
    hold(1'b1, 3);
    check("bnc_dout_e7", dout_a, 1'b0);
    hold(1'b1, 1);
    check("bnc_dout_e8", dout_a, 1'b1);
    check("bnc_rise_e8", rise_a, 1'b1);
    hold(1'b1, 2);

    // Falling edge from STABLE_HI
    tog_save = toggle_a;
    evt_save = evt_a;
    hold(1'b0, 3);
    check("fall_dout_e3", dout_a, 1'b1);
    hold(1'b0, 1);
    check("fall_dout_e4", dout_a,   1'b0);
    check("fall_pulse",   fall_a,   1'b1);
    check("fall_rise",    rise_a,   1'b0);
    check("fall_toggle",  toggle_a, tog_save);
    check("fall_evt",     evt_a,    evt_save);
    hold(1'b0, 1);
    check("fall_one_cycle", fall_a, 1'b0);

    // Reset mid-qualification
    hold(1'b1, 2);
    cycle(1'b1, 1'b0);
    check("midrst_rise", rise_a, 1'b0);
    hold(1'b1, 3);
    check("midrst_dout_e3", dout_a, 1'b0);
    hold(1'b1, 1);
    check("midrst_dout_e4", dout_a, 1'b1);
    hold(1'b1, 1);

    // Counter wrap: 256 press/release cycles with random bounces and holds
    cycle(1'b0, 1'b0);
    n_rise = 0;
    n_fall = 0;
    for (int p = 0; p < 256; p++) begin
      if ($urandom_range(0, 1) == 1) begin
        hold(1'b1, $urandom_range(1, S_A - 1));
        hold(1'b0, 1);
      end
      hold(1'b1, S_A + $urandom_range(0, 3));
      if (p == 254) check("wrap_evt_255", evt_a, 8'd255);
      if (p == 255) check("wrap_evt_0", evt_a, 8'd0);
      if ($urandom_range(0, 1) == 1) begin
        hold(1'b0, $urandom_range(1, S_A - 1));
        hold(1'b1, 1);
      end
      hold(1'b0, S_A + $urandom_range(0, 3));
    end
    check("wrap_toggle", toggle_a, 1'b0);
    check("wrap_nrise",  n_rise,   256);
    check("wrap_nfall",  n_fall,   256);

    // Random levels with short runs, model-checked each cycle
    for (int k = 0; k < 120; k++) begin
      b = $urandom_range(0, 1);
      hold(b[0], $urandom_range(1, 6));
    end

    // Single-cycle qualification tracks din with one cycle of latency
    cycle(1'b0, 1'b0);
    hold(1'b0, 1);
    check("s1_dout_0", dout_b, 1'b0);
    hold(1'b1, 1);
    check("s1_dout_1", dout_b, 1'b1);
    check("s1_rise_1", rise_b, 1'b1);
    hold(1'b0, 1);
    check("s1_dout_2", dout_b, 1'b0);
    check("s1_fall_2", fall_b, 1'b1);
    check("s1_rise_2", rise_b, 1'b0);
    hold(1'b1, 1);
    check("s1_rise_3", rise_b, 1'b1);
    hold(1'b0, 1);
    check("s1_fall_4", fall_b, 1'b1);
    check("s1_evt",    evt_b,  8'd2);
    hold(1'b0, 1);
    check("s1_fall_one_cycle", fall_b, 1'b0);

    check("sb_drained", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
